// File: rtl/jtframe_joymap.sv
// rtl/jtframe_joymap.sv - player input conditioner: rotation, cleanup, autofire, coin stretch
module jtframe_joymap #(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 2,
  parameter int AUTOFIRE_DIV = 8,
  parameter int COIN_FRAMES  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          LVBL,
  input  logic                          rot_en,
  input  logic                          flip,
  input  logic [PLAYERS-1:0]            autofire_en,
  input  logic [PLAYERS*(BUTTONS+4)-1:0] joy_in,
  input  logic [PLAYERS-1:0]            coin_in,
  input  logic [PLAYERS-1:0]            start_in,
  output logic [PLAYERS*(BUTTONS+4)-1:0] game_joy,
  output logic [PLAYERS-1:0]            game_coin,
  output logic [PLAYERS-1:0]            game_start
);

  localparam int JW   = BUTTONS + 4;
  localparam int AFW  = (AUTOFIRE_DIV > 2) ? $clog2(AUTOFIRE_DIV) : 1;
  localparam int CW   = $clog2(COIN_FRAMES + 1);
  localparam int HALF = AUTOFIRE_DIV / 2;

  logic [PLAYERS*JW-1:0] r_joy;
  logic [PLAYERS-1:0]    r_coin, r_coin_d, r_start, r_b0_d;
  logic                  r_lvbl, r_rot, r_flip;
  logic [AFW-1:0]        r_af_cnt   [PLAYERS];
  logic [CW-1:0]         r_coin_cnt [PLAYERS];

  logic                  w_tick;
  logic [PLAYERS*JW-1:0] w_joy_n;
  logic [PLAYERS-1:0]    w_coin_act, w_b0;
  logic [AFW-1:0]        w_af_next   [PLAYERS];
  logic [CW-1:0]         w_coin_next [PLAYERS];
  logic [3:0]            w_dir, w_rd;
  logic                  w_held, w_hold_on, w_coin_edge, w_b0_out;

  assign w_tick = r_lvbl & ~LVBL;

  always_comb begin
    w_joy_n     = '0;
    w_coin_act  = '0;
    w_b0        = '0;
    w_dir       = '0;
    w_rd        = '0;
    w_held      = 1'b0;
    w_hold_on   = 1'b0;
    w_coin_edge = 1'b0;
    w_b0_out    = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      w_af_next[p]   = '0;
      w_coin_next[p] = r_coin_cnt[p];

      // direction bits are {up, down, left, right}
      w_dir = r_joy[p*JW +: 4];
      if (!r_rot)
        w_rd = w_dir;
      else if (!r_flip)
        w_rd = {w_dir[1], w_dir[0], w_dir[2], w_dir[3]};
      else
        w_rd = {w_dir[0], w_dir[1], w_dir[3], w_dir[2]};
      if (w_rd[0] && w_rd[1]) w_rd[1:0] = 2'b00;
      if (w_rd[2] && w_rd[3]) w_rd[3:2] = 2'b00;

      w_held    = r_joy[p*JW + 4];
      w_b0[p]   = w_held;
      w_hold_on = w_held & r_b0_d[p];
      w_b0_out  = w_held;
      if (autofire_en[p]) begin
        w_b0_out = w_held && (r_af_cnt[p] < AFW'(HALF));
        if (!w_hold_on)
          w_af_next[p] = '0;
        else if (w_tick)
          w_af_next[p] = (r_af_cnt[p] == AFW'(AUTOFIRE_DIV - 1)) ? '0 : r_af_cnt[p] + AFW'(1);
        else
          w_af_next[p] = r_af_cnt[p];
      end

      w_joy_n[p*JW +: JW] = {r_joy[p*JW + 4 +: BUTTONS], w_rd};
      w_joy_n[p*JW + 4]   = w_b0_out;

      // edges arriving while a pulse is still counting are dropped
      w_coin_edge = r_coin[p] & ~r_coin_d[p];
      if (r_coin_cnt[p] == '0) begin
        if (w_coin_edge) w_coin_next[p] = CW'(COIN_FRAMES);
      end else if (w_tick) begin
        w_coin_next[p] = r_coin_cnt[p] - CW'(1);
      end
      w_coin_act[p] = (w_coin_next[p] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_joy      <= '0;
      r_coin     <= '0;
      r_coin_d   <= '0;
      r_start    <= '0;
      r_b0_d     <= '0;
      r_lvbl     <= 1'b0;
      r_rot      <= 1'b0;
      r_flip     <= 1'b0;
      game_joy   <= '1;
      game_coin  <= '1;
      game_start <= '1;
      for (int p = 0; p < PLAYERS; p++) begin
        r_af_cnt[p]   <= '0;
        r_coin_cnt[p] <= '0;
      end
    end else begin
      r_joy      <= joy_in;
      r_coin     <= coin_in;
      r_coin_d   <= r_coin;
      r_start    <= start_in;
      r_b0_d     <= w_b0;
      r_lvbl     <= LVBL;
      r_rot      <= rot_en;
      r_flip     <= flip;
      game_joy   <= ~w_joy_n;
      game_coin  <= ~w_coin_act;
      game_start <= ~r_start;
      for (int p = 0; p < PLAYERS; p++) begin
        r_af_cnt[p]   <= w_af_next[p];
        r_coin_cnt[p] <= w_coin_next[p];
      end
    end
  end

endmodule
